spi_frame_rx: RTL and testbench
===============================

Name: spi_frame_rx

Overview:
- Front-end SPI slave stage: deframes the serial MOSI stream into 24-bit command words for the configuration memory stage directly downstream.
- Validates the address field of each word and forwards only valid words.
- Keeps frame and error counters.
- Returns a 24-bit status word on MISO: device identificator, frame count, error count.
- Runs entirely in the i_SPI_CLK domain. The downstream stage resynchronises o_frame_tgl into its own clock.

Parameters:
- FRAME_BITS, 24, bits per frame. Must be ≥ 16.
- ID_CODE, 8'hB0, device identificator returned in every status word.
- MAX_ADDR, 8'h0A, highest valid address value in frame bits [23:16].

Ports:
- i_SPI_CLK  in  1  SPI serial clock. Only clock of the block.
- w_main_reset  in  1  asynchronous, active-high reset.
- i_SPI_CS  in  1  chip select, active low. Sampled on i_SPI_CLK edges.
- i_SPI_MOSI  in  1  serial data, MSB first.
- o_SPI_MISO  out  1  serial status data, MSB first.
- o_frame  out  24  last accepted word: [23:16] address, [15:0] data.
- o_frame_tgl  out  1  toggles once per accepted word.
- o_frame_cnt  out  8  accepted-frame counter, wraps.
- o_err_cnt  out  4  rejected-frame counter, saturating.

Behaviour:
- Reset: all outputs and internal state go to 0, except the MISO shift register, which loads {ID_CODE, 16'h0000}. o_SPI_MISO = ID_CODE[7] = 1.
- Clocking:
  - Receive shift register and bit counter (0..FRAME_BITS-1) update on posedge i_SPI_CLK.
  - MISO shift register updates on negedge i_SPI_CLK (SPI mode 0).
- Posedge with i_SPI_CS=1: bit counter cleared to 0. The partial word is discarded. No counter changes.
- Posedge with i_SPI_CS=0: shift register takes {sr[22:0], MOSI}.
  - If the counter is not FRAME_BITS-1, it increments.
  - If the counter is FRAME_BITS-1, this is the frame-complete edge and the counter wraps to 0. Back-to-back frames under one continuous CS-low are allowed: bit 25 starts the next frame.
- Frame-complete edge, with the completed word W = {sr[22:0], MOSI}:
  - W[23:16] ≤ MAX_ADDR: o_frame ← W, o_frame_tgl inverts, o_frame_cnt increments (8'hFF→8'h00).
  - W[23:16] > MAX_ADDR: o_frame and o_frame_tgl hold. o_err_cnt increments, saturating at 4'hF.
  - All updates visible right after that edge, i.e. latency 0 cycles from the last bit.
- o_frame is stable for at least FRAME_BITS SPI_CLK cycles after each toggle. A downstream 2-flop toggle synchroniser is sufficient.
- MISO status word S = {ID_CODE, o_frame_cnt, o_err_cnt, 4'b0000}.
  - S is loaded on the negedge that ends the last bit of a frame (counter 0 after wrap). It therefore reflects counts including that just-completed frame.
  - S is also loaded on any negedge while i_SPI_CS=1.
  - Otherwise, with i_SPI_CS=0, the register shifts left, filling with 0.
  - o_SPI_MISO = register MSB. It is driven whatever the CS state; pad tri-stating is outside this block.
- Reset mid-frame: immediate clear. The next frame starts at bit 0 after reset deassertion and the first CS-low posedge.
- CS high and the frame-complete condition cannot coincide; CS high always takes priority and discards.
- Counters do not change on discarded (short) frames.

Test Plan:
- Reset, then one frame 24'h03_1234 with CS low → o_frame=24'h031234, o_frame_tgl=1, o_frame_cnt=1, o_err_cnt=0, after the 24th posedge.
- Frame 24'h0B_FFFF (addr > MAX_ADDR) → o_frame unchanged, tgl unchanged, o_err_cnt=1. Send 20 such frames → o_err_cnt stays at 4'hF.
- 10 bits of 24'h05_0000, CS high for 2 clocks, then full frame 24'h01_00AA → only 24'h0100AA accepted, o_frame_cnt increments by exactly 1.
- Three back-to-back frames 24'h00_0001, 24'h01_0002, 24'h02_0003 under one CS low (72 clocks) → tgl toggles 3 times, final o_frame=24'h020003, o_frame_cnt=3.
- MISO readback: after 2 accepted and 1 rejected frame, clock the next frame → MISO bits = 24'hB0_02_10 MSB first, sampled on posedges. Reset value on MISO before the first clock = 1.
- Assert w_main_reset at bit 12 of a frame → all outputs are 0 asynchronously (MISO=1). The subsequent full frame 24'h04_5678 is accepted with o_frame_cnt=1.
- Run 256 valid frames → o_frame_cnt wraps to 8'h00, tgl equals its start value.

Source files
------------

// File: rtl/spi_frame_rx.sv
// SPI slave front end: deframes MOSI into command words, validates the address,
// keeps frame/error counters and returns a status word on MISO (SPI mode 0).
module spi_frame_rx #(
  parameter int unsigned FRAME_BITS = 24,
  parameter logic [7:0]  ID_CODE    = 8'hB0,
  parameter logic [7:0]  MAX_ADDR   = 8'h0A
) (
  input  logic                  i_SPI_CLK,
  input  logic                  w_main_reset,
  input  logic                  i_SPI_CS,
  input  logic                  i_SPI_MOSI,
  output logic                  o_SPI_MISO,
  output logic [FRAME_BITS-1:0] o_frame,
  output logic                  o_frame_tgl,
  output logic [7:0]            o_frame_cnt,
  output logic [3:0]            o_err_cnt
);

  localparam int unsigned CntW = $clog2(FRAME_BITS);
  localparam logic [CntW-1:0] LastBit = CntW'(FRAME_BITS - 1);

  logic [FRAME_BITS-2:0] r_shift, w_shift_nxt;
  logic [CntW-1:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [FRAME_BITS-1:0] r_frame, w_frame_nxt;
  logic                  r_frame_tgl, w_frame_tgl_nxt;
  logic [7:0]            r_frame_cnt, w_frame_cnt_nxt;
  logic [3:0]            r_err_cnt, w_err_cnt_nxt;
  logic [23:0]           r_miso;
  logic [FRAME_BITS-1:0] w_word;
  logic [23:0]           w_status;
  logic                  w_last;

  assign w_word   = {r_shift, i_SPI_MOSI};
  assign w_last   = (r_bit_cnt == LastBit);
  assign w_status = {ID_CODE, r_frame_cnt, r_err_cnt, 4'b0000};

  always_comb begin
    w_shift_nxt     = r_shift;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_frame_nxt     = r_frame;
    w_frame_tgl_nxt = r_frame_tgl;
    w_frame_cnt_nxt = r_frame_cnt;
    w_err_cnt_nxt   = r_err_cnt;
    if (i_SPI_CS) begin
      // Deselect discards any partial word; the stale shift contents are harmless.
      w_bit_cnt_nxt = '0;
    end else begin
      w_shift_nxt = w_word[FRAME_BITS-2:0];
      if (w_last) begin
        w_bit_cnt_nxt = '0;
        if (w_word[FRAME_BITS-1 -: 8] <= MAX_ADDR) begin
          w_frame_nxt     = w_word;
          w_frame_tgl_nxt = ~r_frame_tgl;
          w_frame_cnt_nxt = r_frame_cnt + 8'd1;
        end else if (r_err_cnt != 4'hF) begin
          w_err_cnt_nxt = r_err_cnt + 4'd1;
        end
      end else begin
        w_bit_cnt_nxt = r_bit_cnt + CntW'(1);
      end
    end
  end

  always_ff @(posedge i_SPI_CLK or posedge w_main_reset) begin
    if (w_main_reset) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_frame     <= '0;
      r_frame_tgl <= 1'b0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_shift     <= w_shift_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_frame     <= w_frame_nxt;
      r_frame_tgl <= w_frame_tgl_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
    end
  end

  // Counter at 0 with CS low means a frame just completed, so the reload
  // already carries that frame's counts for the master's next read.
  always_ff @(negedge i_SPI_CLK or posedge w_main_reset) begin
    if (w_main_reset) begin
      r_miso <= {ID_CODE, 16'h0000};
    end else if (i_SPI_CS || (r_bit_cnt == '0)) begin
      r_miso <= w_status;
    end else begin
      r_miso <= {r_miso[22:0], 1'b0};
    end
  end

  assign o_SPI_MISO  = r_miso[23];
  assign o_frame     = r_frame;
  assign o_frame_tgl = r_frame_tgl;
  assign o_frame_cnt = r_frame_cnt;
  assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Randomized bench for spi_frame_rx: a word-level reference model is compared
// against the DUT on every posedge, plus literal checks for directed scenarios.
module tb_spi_frame_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        mosi;
  logic        miso;
  logic [23:0] frame;
  logic        tgl;
  logic [7:0]  fcnt;
  logic [3:0]  ecnt;

  int total = 0;
  int bad   = 0;

  spi_frame_rx dut (
    .i_SPI_CLK   (clk),
    .w_main_reset(rst),
    .i_SPI_CS    (cs),
    .i_SPI_MOSI  (mosi),
    .o_SPI_MISO  (miso),
    .o_frame     (frame),
    .o_frame_tgl (tgl),
    .o_frame_cnt (fcnt),
    .o_err_cnt   (ecnt)
  );

  always #5 clk = ~clk;

  // Reference model: bits collected per frame, word-level accept/reject rules.
  logic [4:0]  m_nbits;
  logic [23:0] m_acc;
  logic [23:0] m_frame;
  logic        m_tgl;
  logic [7:0]  m_fcnt;
  logic [3:0]  m_ecnt;
  logic [23:0] m_snap;
  logic [23:0] rd;

  function automatic logic [23:0] status_word();
    return {8'hB0, m_fcnt, m_ecnt, 4'h0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_nbits = '0;
    m_acc   = '0;
    m_frame = '0;
    m_tgl   = 1'b0;
    m_fcnt  = '0;
    m_ecnt  = '0;
    m_snap  = status_word();
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      if (!cs) begin
        // The master reads the status word as it stood when this frame began.
        if (m_nbits == 5'd0) m_snap = status_word();
        chk("miso_bit", 32'(miso), 32'(m_snap[5'd23 - m_nbits]));
        m_acc   = (m_acc << 1) | 24'(mosi);
        m_nbits = m_nbits + 5'd1;
        if (m_nbits == 5'd24) begin
          m_nbits = '0;
          if (m_acc[23:16] <= 8'h0A) begin
            m_frame = m_acc;
            m_tgl   = ~m_tgl;
            m_fcnt  = m_fcnt + 8'd1;
          end else if (m_ecnt != 4'hF) begin
            m_ecnt = m_ecnt + 4'd1;
          end
        end
      end else begin
        m_nbits = '0;
        m_acc   = '0;
      end
      #1;
      if (!rst) begin
        chk("model_frame", 32'(frame), 32'(m_frame));
        chk("model_tgl", 32'(tgl), 32'(m_tgl));
        chk("model_fcnt", 32'(fcnt), 32'(m_fcnt));
        chk("model_ecnt", 32'(ecnt), 32'(m_ecnt));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    cs = 1'b1;
    repeat (n) tick();
  endtask

  // MISO is captured before each posedge, i.e. the value the master samples.
  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      cs   = 1'b0;
      mosi = w[23];
      w    = w << 1;
      rd   = {rd[22:0], miso};
      tick();
    end
  endtask

  task automatic send_frame(input logic [23:0] w);
    send_bits(w, 24);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cs  = 1'b1;
    #1;
    chk("rst_frame", 32'(frame), 32'h0);
    chk("rst_tgl", 32'(tgl), 32'h0);
    chk("rst_fcnt", 32'(fcnt), 32'h0);
    chk("rst_ecnt", 32'(ecnt), 32'h0);
    chk("rst_miso", 32'(miso), 32'h1);
    model_clear();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        tgl0;
    logic [7:0]  addr;
    rst  = 1'b1;
    cs   = 1'b1;
    mosi = 1'b0;
    rd   = '0;
    model_clear();
    #1;
    chk("miso_before_clock", 32'(miso), 32'h1);
    do_reset();

    // Single valid frame.
    send_frame(24'h031234);
    chk("f1_frame", 32'(frame), 32'h031234);
    chk("f1_tgl", 32'(tgl), 32'h1);
    chk("f1_fcnt", 32'(fcnt), 32'h1);
    chk("f1_ecnt", 32'(ecnt), 32'h0);
    idle(2);

    // Invalid address, then error saturation.
    send_frame(24'h0BFFFF);
    chk("bad_frame_hold", 32'(frame), 32'h031234);
    chk("bad_tgl_hold", 32'(tgl), 32'h1);
    chk("bad_ecnt1", 32'(ecnt), 32'h1);
    for (int i = 0; i < 20; i++) send_frame(24'h0BFFFF);
    chk("ecnt_sat", 32'(ecnt), 32'hF);
    chk("ecnt_sat_fcnt", 32'(fcnt), 32'h1);
    idle(2);

    // Aborted partial frame is discarded.
    do_reset();
    send_bits(24'h050000, 10);
    idle(2);
    send_frame(24'h0100AA);
    chk("abort_frame", 32'(frame), 32'h0100AA);
    chk("abort_fcnt", 32'(fcnt), 32'h1);
    chk("abort_ecnt", 32'(ecnt), 32'h0);
    idle(2);

    // Three back-to-back frames under one CS low.
    do_reset();
    send_frame(24'h000001);
    send_frame(24'h010002);
    send_frame(24'h020003);
    chk("b2b_frame", 32'(frame), 32'h020003);
    chk("b2b_tgl", 32'(tgl), 32'h1);
    chk("b2b_fcnt", 32'(fcnt), 32'h3);
    idle(2);

    // MISO status readback after 2 accepted and 1 rejected frame.
    do_reset();
    send_frame(24'h000001);
    send_frame(24'h0A0002);
    send_frame(24'h0C0000);
    idle(2);
    send_frame(24'h070000);
    chk("miso_word", 32'(rd), 32'hB00210);
    idle(2);

    // Reset in the middle of a frame.
    send_bits(24'h09ABCD, 12);
    do_reset();
    send_frame(24'h045678);
    chk("midrst_frame", 32'(frame), 32'h045678);
    chk("midrst_fcnt", 32'(fcnt), 32'h1);
    idle(2);

    // 256 valid frames wrap the frame counter.
    do_reset();
    tgl0 = tgl;
    for (int i = 0; i < 256; i++) begin
      addr = 8'($urandom_range(0, 10));
      send_frame({addr, 16'($urandom)});
    end
    chk("wrap_fcnt", 32'(fcnt), 32'h0);
    chk("wrap_tgl", 32'(tgl), 32'(tgl0));
    idle(2);

    // Randomized traffic: valid/invalid frames, short frames, gaps, resets.
    for (int n = 0; n < 300; n++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 2) begin
        send_bits(24'($urandom), int'($urandom_range(1, 23)));
        idle(int'($urandom_range(1, 3)));
      end else if (r == 2) begin
        send_bits(24'($urandom), int'($urandom_range(0, 23)));
        do_reset();
      end else begin
        addr = 8'($urandom_range(0, 15));
        send_frame({addr, 16'($urandom)});
        if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
      end
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
